// File: rtl/instr_fetch_pkg.sv
// Shared constants and helpers for the instruction fetch stage.
package instr_fetch_pkg;

    // Instructions delivered by instr_mem per access.
    localparam int unsigned FETCH_WIDTH = 2;

    // NOOP encoding (sll r0, r0, 0); driven on empty decode slots.
    localparam logic [31:0] NOOP = 32'h0000_0000;

    // Limit a decode consume request to the number of slots actually shown.
    function automatic logic [1:0] clamp_take(input logic [1:0] take,
                                              input logic       v0,
                                              input logic       v1);
        logic [1:0] avail;
        avail = v1 ? 2'd2 : (v0 ? 2'd1 : 2'd0);
        return (take > avail) ? avail : take;
    endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Fetch-stage bus: redirect/halt control, instr_mem side and decode side.
interface instr_fetch_if #(
    parameter int unsigned AW = 30
) ();
    logic          redir_valid;
    logic [AW-1:0] redir_pc;
    logic          halt;
    logic [AW-1:0] addr_out;
    logic [31:0]   instr0_in;
    logic [31:0]   instr1_in;
    logic          dec_valid0;
    logic [31:0]   dec_instr0;
    logic [AW-1:0] dec_pc0;
    logic          dec_valid1;
    logic [31:0]   dec_instr1;
    logic [AW-1:0] dec_pc1;
    logic [1:0]    dec_take;

    // Fetch stage side.
    modport master (
        input  redir_valid, redir_pc, halt, instr0_in, instr1_in, dec_take,
        output addr_out, dec_valid0, dec_instr0, dec_pc0, dec_valid1, dec_instr1, dec_pc1
    );

    // Environment side (memory, decode, branch unit).
    modport slave (
        output redir_valid, redir_pc, halt, instr0_in, instr1_in, dec_take,
        input  addr_out, dec_valid0, dec_instr0, dec_pc0, dec_valid1, dec_instr1, dec_pc1
    );
endinterface

// File: rtl/instr_fetch_queue.sv
// Circular buffer of {pc, instr}: two writes per fill, 0-2 reads, flush.
module instr_fetch_queue
    import instr_fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned AW    = 30
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       flush_i,
    input  logic                       wr_en_i,
    input  logic [AW-1:0]              wr_pc_i,
    input  logic [31:0]                wr_instr0_i,
    input  logic [31:0]                wr_instr1_i,
    input  logic [1:0]                 take_i,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       rd_valid0_o,
    output logic [31:0]                rd_instr0_o,
    output logic [AW-1:0]              rd_pc0_o,
    output logic                       rd_valid1_o,
    output logic [31:0]                rd_instr1_o,
    output logic [AW-1:0]              rd_pc1_o
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [AW-1:0] pc_mem_q    [DEPTH];
    logic [31:0]   instr_mem_q [DEPTH];
    logic [PW-1:0] head_q, head_d, tail_q, tail_d, head_p1, tail_p1;
    logic [CW-1:0] count_q, count_d;
    logic [1:0]    take_eff;
    logic          valid0, valid1;

    assign valid0   = (count_q != '0);
    assign valid1   = (count_q > CW'(1));
    assign head_p1  = head_q + PW'(1);
    assign tail_p1  = tail_q + PW'(1);
    assign take_eff = clamp_take(take_i, valid0, valid1);
    assign count_o  = count_q;

    // Decode view straight from storage; empty slots show NOOP at pc 0.
    always_comb begin
        rd_valid0_o = valid0;
        rd_valid1_o = valid1;
        rd_instr0_o = valid0 ? instr_mem_q[head_q]  : NOOP;
        rd_pc0_o    = valid0 ? pc_mem_q[head_q]     : '0;
        rd_instr1_o = valid1 ? instr_mem_q[head_p1] : NOOP;
        rd_pc1_o    = valid1 ? pc_mem_q[head_p1]    : '0;
    end

    // Pointer/count update; flush discards everything including a same-cycle fill.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush_i) begin
            head_d  = tail_q;
            count_d = '0;
        end else begin
            head_d  = head_q + PW'(take_eff);
            tail_d  = wr_en_i ? tail_q + PW'(FETCH_WIDTH) : tail_q;
            count_d = count_q + (wr_en_i ? CW'(FETCH_WIDTH) : CW'(0)) - CW'(take_eff);
        end
    end

    // Pointer and count registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry storage; contents beyond count are never shown, so no reset needed.
    always_ff @(posedge clk_i) begin
        if (wr_en_i && !flush_i) begin
            pc_mem_q[tail_q]     <= wr_pc_i;
            instr_mem_q[tail_q]  <= wr_instr0_i;
            pc_mem_q[tail_p1]    <= wr_pc_i + AW'(1);
            instr_mem_q[tail_p1] <= wr_instr1_i;
        end
    end

    // Decode must not consume more than it is shown (redirect cycles ignore take).
    a_take_legal: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !flush_i |-> ((take_i == 2'd0) || (take_i == 2'd1 && valid0) ||
                      (take_i == 2'd2 && valid1)));

    // The issue rule upstream must leave room for every fill.
    a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (wr_en_i && !flush_i) |-> (32'(count_q) + FETCH_WIDTH <= DEPTH));

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: PC generation, one-deep in-flight tracking, redirect/halt handling.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter int unsigned    DEPTH    = 8,
    parameter int unsigned    AW       = 30,
    parameter logic [AW-1:0]  RESET_PC = '0
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    instr_fetch_if.master bus_io
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic [AW-1:0] pc_q, pc_d;
    logic [AW-1:0] fetch_pc_q, fetch_pc_d;
    logic          inflight_q, inflight_d;
    logic          issue;
    logic [CW-1:0] count;

    assign bus_io.addr_out = pc_q;

    // Conservative issue: reserve room for the in-flight pair and the new one.
    always_comb begin
        issue = !bus_io.halt && !bus_io.redir_valid &&
                ((32'(count) + (inflight_q ? 32'd2 : 32'd0) + 32'd2) <= DEPTH);
    end

    // Next PC and in-flight pipeline register; redirect wins over everything.
    always_comb begin
        pc_d       = pc_q;
        fetch_pc_d = fetch_pc_q;
        inflight_d = 1'b0;
        if (bus_io.redir_valid) begin
            pc_d = bus_io.redir_pc;
        end else if (issue) begin
            pc_d       = pc_q + AW'(FETCH_WIDTH);
            fetch_pc_d = pc_q;
            inflight_d = 1'b1;
        end
    end

    // PC and in-flight state registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pc_q       <= RESET_PC;
            fetch_pc_q <= '0;
            inflight_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            fetch_pc_q <= fetch_pc_d;
            inflight_q <= inflight_d;
        end
    end

    instr_fetch_queue #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_queue (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .flush_i     (bus_io.redir_valid),
        .wr_en_i     (inflight_q),
        .wr_pc_i     (fetch_pc_q),
        .wr_instr0_i (bus_io.instr0_in),
        .wr_instr1_i (bus_io.instr1_in),
        .take_i      (bus_io.dec_take),
        .count_o     (count),
        .rd_valid0_o (bus_io.dec_valid0),
        .rd_instr0_o (bus_io.dec_instr0),
        .rd_pc0_o    (bus_io.dec_pc0),
        .rd_valid1_o (bus_io.dec_valid1),
        .rd_instr1_o (bus_io.dec_instr1),
        .rd_pc1_o    (bus_io.dec_pc1)
    );

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: queue-based reference model plus directed literal checks.
module tb_instr_fetch;
    localparam int unsigned AW    = 30;
    localparam int unsigned DEPTH = 8;

    logic clk_i  = 1'b0;
    logic rst_ni = 1'b0;
    always #5 clk_i = ~clk_i;

    instr_fetch_if #(.AW(AW)) bus ();

    instr_fetch #(
        .DEPTH    (DEPTH),
        .AW       (AW),
        .RESET_PC (30'd0)
    ) dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .bus_io (bus)
    );

    // Synchronous instruction memory returning the word address as data.
    logic [AW-1:0] mem_addr_q = '0;
    always @(posedge clk_i) mem_addr_q <= bus.addr_out;
    assign bus.instr0_in = {2'b00, mem_addr_q};
    assign bus.instr1_in = {2'b00, mem_addr_q + 30'd1};

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: fetched entries in a plain queue, one outstanding pair.
    typedef struct {
        logic [AW-1:0] pc;
        logic [31:0]   instr;
    } ent_t;

    ent_t          m_q[$];
    logic [AW-1:0] m_pc  = '0;
    logic [AW-1:0] m_fpc = '0;
    bit            m_inf = 1'b0;

    task automatic model_step();
        int            sz;
        int            n_take;
        bit            iss;
        logic [AW-1:0] nxt;
        sz  = m_q.size();
        iss = !bus.halt && !bus.redir_valid && (sz + (m_inf ? 2 : 0) + 2 <= int'(DEPTH));
        if (bus.redir_valid) begin
            m_q.delete();
            m_inf = 1'b0;
            m_pc  = bus.redir_pc;
        end else begin
            n_take = int'(bus.dec_take);
            if (n_take > sz) n_take = sz;
            repeat (n_take) void'(m_q.pop_front());
            if (m_inf) begin
                nxt = m_fpc + 30'd1;
                m_q.push_back('{m_fpc, {2'b00, m_fpc}});
                m_q.push_back('{nxt, {2'b00, nxt}});
            end
            if (iss) begin
                m_fpc = m_pc;
                m_pc  = m_pc + 30'd2;
                m_inf = 1'b1;
            end else begin
                m_inf = 1'b0;
            end
        end
    endtask

    initial begin
        forever begin
            @(posedge clk_i or negedge rst_ni);
            if (!rst_ni) begin
                m_q.delete();
                m_pc  = '0;
                m_fpc = '0;
                m_inf = 1'b0;
            end else begin
                model_step();
            end
        end
    end

    task automatic compare_all();
        int sz;
        sz = m_q.size();
        chk("addr_out",   64'(bus.addr_out),   64'(m_pc));
        chk("dec_valid0", 64'(bus.dec_valid0), 64'(sz >= 1));
        chk("dec_instr0", 64'(bus.dec_instr0), (sz >= 1) ? 64'(m_q[0].instr) : 64'd0);
        chk("dec_pc0",    64'(bus.dec_pc0),    (sz >= 1) ? 64'(m_q[0].pc) : 64'd0);
        chk("dec_valid1", 64'(bus.dec_valid1), 64'(sz >= 2));
        chk("dec_instr1", 64'(bus.dec_instr1), (sz >= 2) ? 64'(m_q[1].instr) : 64'd0);
        chk("dec_pc1",    64'(bus.dec_pc1),    (sz >= 2) ? 64'(m_q[1].pc) : 64'd0);
    endtask

    bit cmp_en = 1'b0;
    always @(negedge clk_i) if (cmp_en) compare_all();

    // Run n cycles asking decode to take up to 'want' per cycle (never more than shown).
    task automatic cyc(input int n, input int want);
        int sz;
        repeat (n) begin
            sz = m_q.size();
            bus.dec_take = 2'((want > sz) ? sz : want);
            @(negedge clk_i);
        end
    endtask

    logic [AW-1:0] prev_pc;

    initial begin
        bus.redir_valid = 1'b0;
        bus.redir_pc    = '0;
        bus.halt        = 1'b0;
        bus.dec_take    = 2'd0;
        repeat (2) @(negedge clk_i);

        // Reset state.
        chk("rst_addr",   64'(bus.addr_out),   64'd0);
        chk("rst_valid0", 64'(bus.dec_valid0), 64'd0);
        chk("rst_valid1", 64'(bus.dec_valid1), 64'd0);
        chk("rst_instr0", 64'(bus.dec_instr0), 64'd0);
        chk("rst_pc1",    64'(bus.dec_pc1),    64'd0);
        cmp_en = 1'b1;
        rst_ni = 1'b1;

        // Idle fill: addresses 0,2,4,... until the queue is full.
        cyc(1, 0);
        chk("fill_addr_2", 64'(bus.addr_out), 64'd2);
        cyc(1, 0);
        chk("fill_addr_4", 64'(bus.addr_out), 64'd4);
        cyc(6, 0);
        chk("fill_addr_stop", 64'(bus.addr_out),   64'd8);
        chk("fill_model_cnt", 64'(m_q.size()),     64'd8);
        chk("fill_pc0",       64'(bus.dec_pc0),    64'd0);
        chk("fill_instr0",    64'(bus.dec_instr0), 64'd0);
        chk("fill_pc1",       64'(bus.dec_pc1),    64'd1);
        chk("fill_instr1",    64'(bus.dec_instr1), 64'd1);

        // Halt while draining one per cycle: pc frozen, queue empties.
        bus.halt = 1'b1;
        cyc(10, 1);
        chk("halt_addr",   64'(bus.addr_out),   64'd8);
        chk("halt_empty",  64'(bus.dec_valid0), 64'd0);
        chk("halt_instr0", 64'(bus.dec_instr0), 64'd0);
        bus.halt = 1'b0;
        cyc(1, 0);
        chk("resume_addr", 64'(bus.addr_out), 64'd10);
        cyc(1, 0);
        chk("resume_v0",  64'(bus.dec_valid0), 64'd1);
        chk("resume_pc0", 64'(bus.dec_pc0),    64'd8);

        // Redirect while full.
        cyc(8, 0);
        chk("pre_redir_full", 64'(bus.dec_valid1), 64'd1);
        bus.redir_valid = 1'b1;
        bus.redir_pc    = 30'h155;
        bus.dec_take    = 2'd2;
        @(negedge clk_i);
        bus.redir_valid = 1'b0;
        chk("redir_addr", 64'(bus.addr_out),   64'h155);
        chk("redir_n1_v0", 64'(bus.dec_valid0), 64'd0);
        cyc(1, 0);
        chk("redir_n2_v0", 64'(bus.dec_valid0), 64'd0);
        cyc(1, 0);
        chk("redir_n3_v0",  64'(bus.dec_valid0), 64'd1);
        chk("redir_n3_pc0", 64'(bus.dec_pc0),    64'h155);
        chk("redir_n3_pc1", 64'(bus.dec_pc1),    64'h156);
        chk("redir_n3_in0", 64'(bus.dec_instr0), 64'h155);

        // Steady stream: one pair per cycle with no bubbles.
        prev_pc = bus.dec_pc0;
        for (int i = 0; i < 10; i++) begin
            cyc(1, 2);
            chk("stream_v1",  64'(bus.dec_valid1), 64'd1);
            chk("stream_pc0", 64'(bus.dec_pc0),    64'(prev_pc + 30'd2));
            prev_pc = bus.dec_pc0;
        end

        // Redirect to the top of the address space: pair wraps to 0.
        bus.redir_valid = 1'b1;
        bus.redir_pc    = 30'h3FFF_FFFF;
        @(negedge clk_i);
        bus.redir_valid = 1'b0;
        bus.dec_take    = 2'd0;
        chk("wrap_addr", 64'(bus.addr_out), 64'h3FFF_FFFF);
        cyc(1, 0);
        chk("wrap_next_addr", 64'(bus.addr_out), 64'd1);
        cyc(1, 0);
        chk("wrap_pc0",    64'(bus.dec_pc0),    64'h3FFF_FFFF);
        chk("wrap_pc1",    64'(bus.dec_pc1),    64'd0);
        chk("wrap_instr1", 64'(bus.dec_instr1), 64'd0);
        chk("wrap_v1",     64'(bus.dec_valid1), 64'd1);
        cyc(6, 2);

        // Asynchronous reset between edges.
        #2 rst_ni = 1'b0;
        #1;
        chk("arst_v0",   64'(bus.dec_valid0), 64'd0);
        chk("arst_v1",   64'(bus.dec_valid1), 64'd0);
        chk("arst_addr", 64'(bus.addr_out),   64'd0);
        chk("arst_pc0",  64'(bus.dec_pc0),    64'd0);
        bus.dec_take = 2'd0;
        @(negedge clk_i);
        rst_ni = 1'b1;
        cyc(1, 0);
        chk("post_rst_addr", 64'(bus.addr_out),   64'd2);
        chk("post_rst_v0a",  64'(bus.dec_valid0), 64'd0);
        cyc(1, 0);
        chk("post_rst_v0b",  64'(bus.dec_valid0), 64'd1);
        chk("post_rst_pc0",  64'(bus.dec_pc0),    64'd0);
        cyc(8, 2);

        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
